// File: rtl/gpr_wr_arbiter_if.sv
// GPR write-port arbiter bundle: WB request, LU completion
// handshake, decode hazard query and the GPR write port.
interface gpr_wr_arbiter_if #(
    parameter int RSZ     = 32,
    parameter int GPR_ASZ = 5
);
    logic               cpu_halt;
    logic               wb_wr_in;
    logic [GPR_ASZ-1:0] wb_addr_in;
    logic [RSZ-1:0]     wb_data_in;
    logic               wb_stall_out;
    logic               lu_valid_in;
    logic [GPR_ASZ-1:0] lu_addr_in;
    logic [RSZ-1:0]     lu_data_in;
    logic               lu_rdy_out;
    logic [GPR_ASZ-1:0] chk_addr_in;
    logic               chk_hit_out;
    logic               gpr_Rd_wr_out;
    logic [GPR_ASZ-1:0] gpr_Rd_addr_out;
    logic [RSZ-1:0]     gpr_Rd_data_out;

    modport master (
        output cpu_halt, wb_wr_in, wb_addr_in, wb_data_in,
        output lu_valid_in, lu_addr_in, lu_data_in, chk_addr_in,
        input  wb_stall_out, lu_rdy_out, chk_hit_out,
        input  gpr_Rd_wr_out, gpr_Rd_addr_out, gpr_Rd_data_out
    );

    modport slave (
        input  cpu_halt, wb_wr_in, wb_addr_in, wb_data_in,
        input  lu_valid_in, lu_addr_in, lu_data_in, chk_addr_in,
        output wb_stall_out, lu_rdy_out, chk_hit_out,
        output gpr_Rd_wr_out, gpr_Rd_addr_out, gpr_Rd_data_out
    );
endinterface

// File: rtl/gpr_wr_arbiter.sv
// Shares the GPR write port between WB (priority) and a
// buffered long-latency unit, with starvation-driven WB stall.
module gpr_wr_arbiter #(
    parameter int RSZ        = 32,
    parameter int GPR_ASZ    = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk_in,
    input  logic            reset_in,
    gpr_wr_arbiter_if.slave bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);
    localparam logic [SW-1:0] SMAX_C  = SW'(STARVE_MAX);

    logic [FIFO_DEPTH-1:0] vld;
    logic [FIFO_DEPTH-1:0] vld_nxt;
    logic [FIFO_DEPTH-1:0] squash;
    logic [GPR_ASZ-1:0]    ent_addr [FIFO_DEPTH];
    logic [RSZ-1:0]        ent_data [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [PW:0]           count;
    logic [SW-1:0]         starve_cnt;
    logic [SW-1:0]         starve_nxt;
    logic                  wb_stall;

    logic                  nonempty;
    logic                  head_vld;
    logic                  lu_rdy;
    logic                  wb_win;
    logic                  pop;
    logic                  fifo_grant;
    logic                  push;
    logic                  hit;
    logic                  gpr_wr;
    logic [GPR_ASZ-1:0]    gpr_addr;
    logic [RSZ-1:0]        gpr_data;

    assign nonempty   = (count != '0);
    assign head_vld   = nonempty & vld[rd_ptr];
    assign lu_rdy     = reset_in & ~bus.cpu_halt & (count < DEPTH_C);
    assign wb_win     = reset_in & bus.wb_wr_in & ~wb_stall
                      & (bus.wb_addr_in != '0);
    // A squashed head is popped silently, so pop ignores its valid bit.
    assign pop        = ~wb_win & nonempty;
    assign fifo_grant = pop & head_vld;
    assign push       = bus.lu_valid_in & lu_rdy
                      & (bus.lu_addr_in != '0);

    always_comb begin
        gpr_wr   = 1'b0;
        gpr_addr = '0;
        gpr_data = '0;
        if (wb_win) begin
            gpr_wr   = 1'b1;
            gpr_addr = bus.wb_addr_in;
            gpr_data = bus.wb_data_in;
        end else if (fifo_grant) begin
            gpr_wr   = 1'b1;
            gpr_addr = ent_addr[rd_ptr];
            gpr_data = ent_data[rd_ptr];
        end
    end

    always_comb begin
        hit    = 1'b0;
        squash = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (vld[i] && ent_addr[i] == bus.chk_addr_in)
                hit = 1'b1;
            squash[i] = wb_win & vld[i]
                      & (ent_addr[i] == bus.wb_addr_in);
        end
        if (bus.chk_addr_in == '0)
            hit = 1'b0;
    end

    always_comb begin
        vld_nxt = vld & ~squash;
        if (pop)
            vld_nxt[rd_ptr] = 1'b0;
        if (push)
            vld_nxt[wr_ptr] = 1'b1;
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (!nonempty || fifo_grant)
            starve_nxt = '0;
        else if (head_vld && starve_cnt != SMAX_C)
            starve_nxt = starve_cnt + 1'b1;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            vld        <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            wb_stall   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            vld        <= vld_nxt;
            count      <= count + (PW+1)'(push) - (PW+1)'(pop);
            starve_cnt <= starve_nxt;
            wb_stall   <= (starve_nxt == SMAX_C) & ~wb_stall;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push) begin
                ent_addr[wr_ptr] <= bus.lu_addr_in;
                ent_data[wr_ptr] <= bus.lu_data_in;
                wr_ptr           <= wr_ptr + 1'b1;
            end
        end
    end

    assign bus.wb_stall_out    = wb_stall;
    assign bus.lu_rdy_out      = lu_rdy;
    assign bus.chk_hit_out     = hit;
    assign bus.gpr_Rd_wr_out   = gpr_wr;
    assign bus.gpr_Rd_addr_out = gpr_addr;
    assign bus.gpr_Rd_data_out = gpr_data;
endmodule

// File: tb/tb_gpr_wr_arbiter.sv
// Vector table plus hand sequences for gpr_wr_arbiter; GPR
// writes are checked in order against an expected-write queue.
module tb_gpr_wr_arbiter;
    logic clk_in   = 1'b0;
    logic reset_in = 1'b0;
    always #5 clk_in = ~clk_in;

    gpr_wr_arbiter_if #(.RSZ(32), .GPR_ASZ(5)) bus ();

    gpr_wr_arbiter #(
        .RSZ(32), .GPR_ASZ(5), .FIFO_DEPTH(2), .STARVE_MAX(4)
    ) dut (
        .clk_in  (clk_in),
        .reset_in(reset_in),
        .bus     (bus)
    );

    typedef struct {
        logic        wb_wr;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        lu_v;
        logic [4:0]  lu_addr;
        logic [31:0] lu_data;
        logic        halt;
        logic [4:0]  chk;
        logic        e_wr;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_rdy;
        logic        e_stall;
        logic        e_hit;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    int   errors = 0;
    int   checks = 0;
    wr_t  exp_q[$];
    wr_t  mon_w;
    vec_t vecs[$];
    vec_t hv;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t v(
        int wb_wr, int wa, int wd, int lv, int la, int ld,
        int h, int c, int ew, int ea, int ed, int er, int es, int eh);
        vec_t r;
        r.wb_wr = 1'(wb_wr); r.wb_addr = 5'(wa); r.wb_data = 32'(wd);
        r.lu_v  = 1'(lv);    r.lu_addr = 5'(la); r.lu_data = 32'(ld);
        r.halt  = 1'(h);     r.chk     = 5'(c);
        r.e_wr  = 1'(ew);    r.e_addr  = 5'(ea); r.e_data  = 32'(ed);
        r.e_rdy = 1'(er);    r.e_stall = 1'(es); r.e_hit   = 1'(eh);
        return r;
    endfunction

    task automatic drive(input vec_t x);
        bus.wb_wr_in    = x.wb_wr;
        bus.wb_addr_in  = x.wb_addr;
        bus.wb_data_in  = x.wb_data;
        bus.lu_valid_in = x.lu_v;
        bus.lu_addr_in  = x.lu_addr;
        bus.lu_data_in  = x.lu_data;
        bus.cpu_halt    = x.halt;
        bus.chk_addr_in = x.chk;
    endtask

    task automatic apply(input vec_t x, input string tag);
        @(posedge clk_in);
        #1;
        drive(x);
        if (x.e_wr)
            exp_q.push_back('{a: x.e_addr, d: x.e_data});
        @(negedge clk_in);
        check({tag, "_wr"}, 32'(bus.gpr_Rd_wr_out), 32'(x.e_wr));
        check({tag, "_rdy"}, 32'(bus.lu_rdy_out), 32'(x.e_rdy));
        check({tag, "_stall"}, 32'(bus.wb_stall_out), 32'(x.e_stall));
        check({tag, "_hit"}, 32'(bus.chk_hit_out), 32'(x.e_hit));
    endtask

    always @(negedge clk_in) begin
        if (bus.gpr_Rd_wr_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL gpr_unexpected: got x%0d=%h expected none",
                         bus.gpr_Rd_addr_out, bus.gpr_Rd_data_out);
            end else begin
                mon_w = exp_q.pop_front();
                check("gpr_addr", 32'(bus.gpr_Rd_addr_out), 32'(mon_w.a));
                check("gpr_data", bus.gpr_Rd_data_out, mon_w.d);
            end
        end
    end

    initial begin
        drive(v(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0));

        // priority
        vecs.push_back(v(0,0,0,      0,0,0,        0,0, 0,0,0,        1,0,0));
        vecs.push_back(v(0,0,0,      1,5,'hAAAA,   0,5, 0,0,0,        1,0,0));
        vecs.push_back(v(1,6,'h1234, 0,0,0,        0,5, 1,6,'h1234,   1,0,1));
        vecs.push_back(v(0,0,0,      0,0,0,        0,5, 1,5,'hAAAA,   1,0,1));
        vecs.push_back(v(0,0,0,      0,0,0,        0,5, 0,0,0,        1,0,0));
        // squash
        vecs.push_back(v(0,0,0,      1,7,'h11,     0,7, 0,0,0,        1,0,0));
        vecs.push_back(v(1,7,'h22,   0,0,0,        0,7, 1,7,'h22,     1,0,1));
        vecs.push_back(v(0,0,0,      0,0,0,        0,7, 0,0,0,        1,0,0));
        vecs.push_back(v(0,0,0,      0,0,0,        0,7, 0,0,0,        1,0,0));
        // x0 on both sides
        vecs.push_back(v(1,0,'h55,   1,0,'hFF,     0,0, 0,0,0,        1,0,0));
        vecs.push_back(v(0,0,0,      0,0,0,        0,0, 0,0,0,        1,0,0));
        // full, then halt
        vecs.push_back(v(1,4,'h44,   1,3,'h33,     0,3, 1,4,'h44,     1,0,0));
        vecs.push_back(v(1,9,'h99,   1,8,'h88,     0,8, 1,9,'h99,     1,0,0));
        vecs.push_back(v(1,10,'hA0,  1,11,'hB1,    0,8, 1,10,'hA0,    0,0,1));
        vecs.push_back(v(0,0,0,      0,0,0,        0,8, 1,3,'h33,     0,0,1));
        vecs.push_back(v(0,0,0,      0,0,0,        0,8, 1,8,'h88,     1,0,1));
        vecs.push_back(v(0,0,0,      1,12,'hCC,    1,0, 0,0,0,        0,0,0));
        vecs.push_back(v(0,0,0,      0,0,0,        1,0, 0,0,0,        0,0,0));
        vecs.push_back(v(0,0,0,      0,0,0,        0,0, 0,0,0,        1,0,0));

        #2;
        check("rst_wr", 32'(bus.gpr_Rd_wr_out), 32'd0);
        check("rst_rdy", 32'(bus.lu_rdy_out), 32'd0);
        check("rst_stall", 32'(bus.wb_stall_out), 32'd0);
        check("rst_hit", 32'(bus.chk_hit_out), 32'd0);
        repeat (2) @(posedge clk_in);
        #1 reset_in = 1'b1;

        foreach (vecs[i])
            apply(vecs[i], $sformatf("v%0d", i));

        // starvation: one buffered entry, WB writing every cycle
        apply(v(0,0,0, 1,13,'hD1, 0,13, 0,0,0, 1,0,0), "st0");
        for (int i = 1; i <= 4; i++)
            apply(v(1,14,'h100+i, 0,0,0, 0,13, 1,14,'h100+i, 1,0,1),
                  $sformatf("st%0d", i));
        apply(v(1,14,'h200, 0,0,0, 0,13, 1,13,'hD1,  1,1,1), "st5");
        apply(v(1,14,'h200, 0,0,0, 0,13, 1,14,'h200, 1,0,0), "st6");
        apply(v(0,0,0,      0,0,0, 0,13, 0,0,0,      1,0,0), "st7");

        // async reset with two buffered entries
        apply(v(1,17,'h17, 1,15,'hF15, 0,15, 1,17,'h17, 1,0,0), "rs1");
        apply(v(1,18,'h18, 1,16,'hF16, 0,15, 1,18,'h18, 1,0,1), "rs2");
        @(posedge clk_in);
        #1;
        drive(v(0,0,0, 0,0,0, 0,15, 0,0,0, 0,0,0));
        #1;
        check("rs_pre_hit", 32'(bus.chk_hit_out), 32'd1);
        check("rs_pre_rdy", 32'(bus.lu_rdy_out), 32'd0);
        reset_in = 1'b0;
        #1;
        check("rs_wr", 32'(bus.gpr_Rd_wr_out), 32'd0);
        check("rs_addr", 32'(bus.gpr_Rd_addr_out), 32'd0);
        check("rs_data", bus.gpr_Rd_data_out, 32'd0);
        check("rs_rdy", 32'(bus.lu_rdy_out), 32'd0);
        check("rs_hit", 32'(bus.chk_hit_out), 32'd0);
        check("rs_stall", 32'(bus.wb_stall_out), 32'd0);
        repeat (2) @(posedge clk_in);
        #1 reset_in = 1'b1;
        @(negedge clk_in);
        check("rel_wr", 32'(bus.gpr_Rd_wr_out), 32'd0);
        check("rel_rdy", 32'(bus.lu_rdy_out), 32'd1);
        check("rel_hit", 32'(bus.chk_hit_out), 32'd0);
        hv = v(0,0,0, 0,0,0, 0,16, 0,0,0, 1,0,0);
        for (int i = 0; i < 3; i++)
            apply(hv, $sformatf("post%0d", i));

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gpr_wr_arbiter.md
Name: gpr_wr_arbiter

Overview:
Shares the single GPR write port between the WB stage and a long-latency completion unit (LU: iterative divide, late loads). WB writes have zero-latency priority. LU results are buffered in a small FIFO and drained into idle port cycles. A starvation counter stalls WB when needed so LU results always retire. The block sits between wb and the GPR file and drives the GPR write port.

Parameters:
RSZ, 32, GPR data width
GPR_ASZ, 5, GPR address width (MAX_GPR = 32)
FIFO_DEPTH, 2, LU result buffer entries (power of 2, >= 2)
STARVE_MAX, 4, consecutive denied cycles before WB is stalled

Ports:
clk_in  in  1  clock
reset_in  in  1  asynchronous, active-low reset
cpu_halt  in  1  stop accepting new LU results; buffered results still drain
wb_wr_in  in  1  WB requests GPR write
wb_addr_in  in  GPR_ASZ  WB destination register
wb_data_in  in  RSZ  WB write data
wb_stall_out  out  1  registered; WB must hold its request this cycle
lu_valid_in  in  1  LU result valid
lu_addr_in  in  GPR_ASZ  LU destination register
lu_data_in  in  RSZ  LU result data
lu_rdy_out  out  1  LU result accepted when valid & rdy
chk_addr_in  in  GPR_ASZ  hazard query address from decode
chk_hit_out  out  1  a valid FIFO entry targets chk_addr_in (comb)
gpr_Rd_wr_out  out  1  GPR write enable
gpr_Rd_addr_out  out  GPR_ASZ  GPR write address
gpr_Rd_data_out  out  RSZ  GPR write data

Behaviour:
- Reset (reset_in=0, async): clear FIFO valid bits, rd/wr pointers, count, starve_cnt and wb_stall_out. Force gpr_Rd_wr_out=0, lu_rdy_out=0 and chk_hit_out=0. Addr/data outputs = 0. Buffered LU results are discarded.
- lu_rdy_out = reset_in & !cpu_halt & (count < FIFO_DEPTH). It is based on the registered count, so there is no push-when-full even if a pop happens in the same cycle.
- Push: on lu_valid_in & lu_rdy_out, enqueue {addr,data} at the tail. If addr == 0, accept the handshake but do not enqueue.
- There is no LU bypass. An LU result reaches the GPR at the earliest 1 cycle after acceptance.
- Grant each cycle (combinational mux, zero latency):
  - wb_win = wb_wr_in & !wb_stall_out & (wb_addr_in != 0).
  - If wb_win, drive the WB request to the GPR port.
  - Otherwise, if the FIFO head is valid, drive the head and pop it.
  - Otherwise, gpr_Rd_wr_out = 0.
  - A WB request to x0 produces no GPR write and frees the port for the FIFO.
- Squash: when wb_win and a valid FIFO entry has addr == wb_addr_in, that entry's valid bit clears at the clock edge. The younger WB write must not be overwritten.
  - Squashed entries stay in place and are skipped at pop time: pop advances the pointer without writing.
  - A squashed entry at the head takes one idle cycle to skip.
- starve_cnt increments when the head is valid and the FIFO is not granted. It clears on a FIFO grant or when the FIFO is empty. It saturates at STARVE_MAX.
- wb_stall_out is set on the edge where starve_cnt reaches STARVE_MAX and is held for exactly one cycle. During that cycle the FIFO is guaranteed the port, and wb_wr_in is ignored (no squash).
- cpu_halt: no new LU pushes. WB and FIFO draining continue normally.
- chk_hit_out is the OR over valid entries of (entry.addr == chk_addr_in). It is 0 when chk_addr_in == 0.
- Each count update is consistent with simultaneous push and pop.

Test Plan:
- Priority: FIFO holds {x5,0xAAAA}, WB writes {x6,0x1234} -> cycle 1 GPR gets x6/0x1234, cycle 2 gets x5/0xAAAA, then count=0.
- Starvation: FIFO holds 1 entry, wb_wr_in=1 every cycle -> wb_stall_out=1 after 4 denied cycles, FIFO entry written in the stall cycle, starve_cnt=0.
- Squash: FIFO holds {x7,0x11}, WB writes {x7,0x22} -> GPR gets x7=0x22 only, entry skipped, chk_hit_out(x7) drops to 0.
- Full/halt: 2 LU pushes with WB busy -> lu_rdy_out=0. Then assert cpu_halt with the FIFO empty -> lu_rdy_out stays 0 and no write occurs.
- x0: LU pushes {x0,0xFF} and WB writes x0 -> lu_rdy handshake completes, gpr_Rd_wr_out never asserts, count stays 0.
- Async reset with 2 entries buffered -> outputs cleared immediately. After release, gpr_Rd_wr_out=0 and lu_rdy_out=1.
